sme_fifo_rr_arbiter: RTL

//  Packet-atomic round-robin arbiter sharing one unified_fifo write port among NUM_IN streams.

---
 rtl/sme_arb_pkg.sv | 17 +
 rtl/sme_fifo_rr_arbiter_rr_pick.sv | 50 +++++
 rtl/sme_fifo_rr_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/sme_arb_pkg.sv
// Shared types and helpers for the SME FIFO round-robin arbiter.
// Provides the arbiter state encoding and the modulo pointer increment.
package sme_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int STALL_W = 32;

    // Next round-robin start position after stream ptr, wrapping at n.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sme_fifo_rr_arbiter_rr_pick.sv
// Combinational rotating priority encoder: returns the first asserted
// request found scanning ptr, ptr+1, ... modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 2) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] gnt_idx,
    output logic         gnt_any
);

    localparam logic [W:0] N_W = (W+1)'(N);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   rot;
    logic [N:0]     below;
    logic [N-1:0]   first;
    logic [W-1:0]   off;
    logic [W:0]     sum;
    logic [W:0]     sum_wrap;

    assign req_dbl = {req, req};
    assign below[0] = 1'b0;

    // rot[k] is the request k positions after ptr; first[] isolates the
    // lowest set rotated bit so the encode below can simply OR.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi]     = req_dbl[{1'b0, ptr} + (W+1)'(gi)];
            assign below[gi+1] = below[gi] | rot[gi];
            assign first[gi]   = rot[gi] & ~below[gi];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = 0; k < N; k++) begin
            if (first[k]) begin
                off = off | W'(k);
            end
        end
    end

    assign sum      = {1'b0, ptr} + {1'b0, off};
    assign sum_wrap = (sum >= N_W) ? (sum - N_W) : sum;
    assign gnt_idx  = sum_wrap[W-1:0];
    assign gnt_any  = |req;

endmodule

// File: rtl/sme_fifo_rr_arbiter.sv
// Packet-atomic round-robin arbiter feeding one FIFO write port from NUM_IN
// streams; beats carry their source id and respect FIFO almost_full.
module sme_fifo_rr_arbiter
    import sme_arb_pkg::*;
#(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 512,
    parameter int ID_W       = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_IN-1:0]            s_valid,
    input  logic [NUM_IN-1:0]            s_last,
    output logic [NUM_IN-1:0]            s_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_valid,
    output logic                         m_last,
    output logic [ID_W-1:0]              m_src,
    input  logic                         m_ready,
    input  logic                         almost_full,
    output logic [STALL_W-1:0]           stall_cnt
);

    arb_state_t              state_reg;
    arb_state_t              state_next;
    logic [ID_W-1:0]         grant_reg;
    logic [ID_W-1:0]         rr_ptr_reg;
    logic [DATA_WIDTH-1:0]   m_data_reg;
    logic                    m_valid_reg;
    logic                    m_last_reg;
    logic [ID_W-1:0]         m_src_reg;
    logic [STALL_W-1:0]      stall_cnt_reg;

    logic [DATA_WIDTH-1:0]   lane_data [NUM_IN];
    logic [ID_W-1:0]         pick_idx;
    logic                    pick_any;
    logic                    out_free;
    logic                    accept;
    logic                    beat_last;
    logic                    end_of_pkt;
    logic                    stall_hit;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
            assign lane_data[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_pick #(
        .N (NUM_IN),
        .W (ID_W)
    ) u_rr_pick (
        .req     (s_valid),
        .ptr     (rr_ptr_reg),
        .gnt_idx (pick_idx),
        .gnt_any (pick_any)
    );

    // The output slot can take a new beat when empty or draining this cycle.
    assign out_free   = !almost_full && (!m_valid_reg || m_ready);
    assign accept     = |(s_valid & s_ready);
    assign beat_last  = s_last[grant_reg];
    assign end_of_pkt = accept && beat_last;
    assign stall_hit  = (state_reg == LOCK) && s_valid[grant_reg] && almost_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (pick_any)   state_next = LOCK;
            LOCK: if (end_of_pkt) state_next = IDLE;
            default:              state_next = IDLE;
        endcase
    end

    always_comb begin
        s_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            s_ready[i] = (state_reg == LOCK) && (grant_reg == ID_W'(i)) && out_free;
        end
    end

    // Grant is captured only in IDLE, so it cannot move mid-packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            if (state_reg == IDLE && pick_any) begin
                grant_reg <= pick_idx;
            end
            if (state_reg == LOCK && end_of_pkt) begin
                rr_ptr_reg <= ID_W'(rr_next(int'(grant_reg), NUM_IN));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_src_reg   <= '0;
            m_data_reg  <= '0;
        end else if (accept) begin
            m_valid_reg <= 1'b1;
            m_last_reg  <= beat_last;
            m_src_reg   <= grant_reg;
            m_data_reg  <= lane_data[grant_reg];
        end else if (m_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_hit && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign m_data    = m_data_reg;
    assign m_valid   = m_valid_reg;
    assign m_last    = m_last_reg;
    assign m_src     = m_src_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule
